// File: rtl/uart_tx_pkg.sv
// Shared types and line levels for the buffered UART transmitter.
// The state set includes PARITY only when UART_TX_PARITY_EN is defined.
package uart_tx_pkg;

  localparam int DATA_BITS = 8;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } tx_state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } tx_state_t;
`endif

endpackage

// File: rtl/sync_fifo_byte.sv
// Synchronous byte FIFO with registered full/empty flags and occupancy.
// count_nxt exposes the post-edge occupancy so callers can register on it.
module sync_fifo_byte #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   count_nxt
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          push_ok, pop_ok;

  assign push_ok   = push && !full_q;
  assign pop_ok    = pop && !empty_q;
  assign dout      = mem_q[rd_ptr_q];
  assign full      = full_q;
  assign empty     = empty_q;
  assign count     = count_q;
  assign count_nxt = count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == (AW+1)'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset; pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter; define UART_TX_PARITY_EN for 8E1 frames.
// FIFO pops straight into START after STOP so queued bytes go back-to-back.
module uart_tx_fifo
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

  tx_state_t   state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
  logic        par_q, par_d;
`endif

  logic        fifo_full, fifo_empty, fifo_pop;
  logic [7:0]  fifo_dout;
  logic [$clog2(FIFO_DEPTH):0] fifo_count_nxt;
  logic        wrap;

  sync_fifo_byte #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_valid),
    .din       (in_data),
    .pop       (fifo_pop),
    .dout      (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .count_nxt (fifo_count_nxt)
  );

  assign in_ready = !fifo_full;
  assign tx       = tx_q;
  assign busy     = busy_q;
  assign wrap     = (baud_q == BAUD_MAX);

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    fifo_pop = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d    = par_q;
`endif
    if (state_q != S_IDLE) baud_d = wrap ? 16'd0 : baud_q + 16'd1;
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          baud_d   = 16'd0;
          state_d  = S_START;
          tx_d     = START_LVL;
`ifdef UART_TX_PARITY_EN
          par_d    = ^fifo_dout;
`endif
        end
      end
      S_START: begin
        if (wrap) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        if (wrap) begin
          if (bit_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = par_q;
`else
            state_d = S_STOP;
            tx_d    = STOP_LVL;
`endif
          end else begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (wrap) begin
          state_d = S_STOP;
          tx_d    = STOP_LVL;
        end
      end
`endif
      S_STOP: begin
        if (wrap) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            state_d  = S_START;
            tx_d     = START_LVL;
`ifdef UART_TX_PARITY_EN
            par_d    = ^fifo_dout;
`endif
          end else begin
            state_d = S_IDLE;
            tx_d    = IDLE_LVL;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = IDLE_LVL;
      end
    endcase
    busy_d = (state_d != S_IDLE) || (fifo_count_nxt != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= 16'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= IDLE_LVL;
      busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule
